ysyx_25020047_ctrl_fsm: RTL and testbench
=========================================

Name: ysyx_25020047_ctrl_fsm

Overview:
Multi-cycle core sequencer for the single-issue RV32 datapath (IFU -> IDU/GPR -> EXU -> LSU -> writeback).
- Drives the instruction-fetch and data-memory request/ack handshakes.
- Gates IR latch, GPR write (reg_wen into the decoder/GPR) and PC update, so each instruction retires in a deterministic multi-cycle sequence.
- Detects ebreak, illegal instructions and memory timeouts, and parks the core in a sticky HALT state with a reason code.

Parameters:
TMO_CYC, 256, max cycles waiting for ifu_ack/lsu_ack before timeout halt (>=2)
CNT_W, 64, width of cycle and retired-instruction counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin execution; sampled only in IDLE
ifu_req  out  1  instruction fetch request
ifu_ack  in  1  fetch data valid this cycle
ir_wen  out  1  latch instruction register
is_load  in  1  decoded class: load (lw/lb/lh/lbu/lhu)
is_store  in  1  decoded class: store (sw/sh/sb)
is_ebreak  in  1  decoded ebreak
is_illegal  in  1  decoder default (inst_type all-ones)
has_rd  in  1  instruction writes rd (0 for stores/branches)
lsu_req  out  1  data memory request
lsu_we  out  1  data request is a write
lsu_ack  in  1  data access complete
reg_wen  out  1  GPR write enable
pc_wen  out  1  PC register takes dnpc
halt  out  1  core halted (sticky)
halt_code  out  2  0 ebreak, 1 illegal, 2 ifu timeout, 3 lsu timeout
state  out  3  current state, debug
cycle_cnt  out  CNT_W  cycles spent outside IDLE/HALT
instret  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, counters 0, timeout counter 0. Reset mid-handshake abandons the transaction; no write enables fire.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is unreachable and recovers to IDLE next edge.
- IDLE: start=1 -> FETCH.
- FETCH: ifu_req=1 (Moore).
  - ifu_ack=1: ir_wen=1 same cycle (Mealy), -> DECODE.
- DECODE: decode inputs valid; they are held stable DECODE..WB because the IR is latched.
  - Priority: is_illegal -> HALT code 1; else is_ebreak -> HALT code 0; else -> EXEC.
  - ebreak does not increment instret.
- EXEC: one ALU cycle. (is_load|is_store) -> MEM; else -> WB.
- MEM: lsu_req=1, lsu_we=is_store.
  - lsu_ack=1: -> WB.
  - Loads write in WB; stores only update the PC.
- WB: reg_wen=has_rd & ~is_store; pc_wen=1; instret+=1 -> FETCH.
- Latency with zero-wait memories (ack in the first request cycle): ALU/branch 4 cycles, load/store 5 cycles.
- Timeout:
  - Counter clears on entering FETCH/MEM and increments each waiting cycle.
  - If the counter reaches TMO_CYC-1 with ack=0 -> HALT code 2 (FETCH) or 3 (MEM).
  - Ack in the same cycle as expiry wins; no timeout is raised.
- Handshake rules:
  - Req stays high until the ack cycle and drops the cycle after.
  - Ack while req=0 is ignored.
  - Ack is a single-cycle pulse per request.
- HALT: halt=1, halt_code held, counters frozen. Only rst exits; start is ignored.
- cycle_cnt increments every cycle with state in {FETCH..WB}. Both counters wrap modulo 2^CNT_W silently.
- Exactly one of ir_wen/reg_wen/pc_wen can be asserted per cycle, except reg_wen+pc_wen together in WB.

Decomposition:
- Shared package ysyx_25020047_ctrl_pkg:
  - state encoding localparams
  - halt codes: HC_EBREAK, HC_ILLEGAL, HC_IFU_TMO, HC_LSU_TMO
  - ILLEGAL_INST_TYPE = 64'hFFFF_FFFF_FFFF_FFFF (the decoder derives is_illegal from it)
- One sub-module: ysyx_25020047_tmo_cnt (clear/enable/expire counter, parameter TMO_CYC), instantiated once.
- Class decode (is_load etc. from inst_type) stays in the IDU, outside this block.

Test Plan:
- Reset, start=1, addi with ifu_ack in the first FETCH cycle -> states 1,2,3,5,1; reg_wen=1 and pc_wen=1 in cycle 4; instret=1, cycle_cnt=4.
- lw with lsu_ack delayed 3 cycles -> lsu_req high 4 cycles with lsu_we=0; reg_wen in WB; 8 cycles from FETCH to next FETCH.
- sw (has_rd=0) -> lsu_we=1 in MEM; WB has reg_wen=0, pc_wen=1.
- is_illegal=1 in DECODE -> halt=1 next cycle, halt_code=1, instret unchanged; later start pulses ignored. Repeat with ebreak -> halt_code=0.
- TMO_CYC=4, ifu_ack never asserted -> HALT code 2 after 4 FETCH cycles. Same with ack in the 4th cycle -> proceeds to DECODE, no halt.
- rst asserted mid-MEM with lsu_req high -> all outputs 0 immediately (async); after release, state=IDLE and counters=0.

Source files
------------

// File: rtl/ysyx_25020047_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020047_ctrl_pkg
// Description : Shared state encoding, halt codes and helpers for the core
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25020047_ctrl_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] HC_EBREAK  = 2'd0;
    localparam logic [1:0] HC_ILLEGAL = 2'd1;
    localparam logic [1:0] HC_IFU_TMO = 2'd2;
    localparam logic [1:0] HC_LSU_TMO = 2'd3;

    // The decoder flags is_illegal when inst_type matches this pattern.
    localparam logic [63:0] ILLEGAL_INST_TYPE = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic is_running(input state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
               (s == S_MEM) || (s == S_WB);
    endfunction

endpackage : ysyx_25020047_ctrl_pkg
`default_nettype wire

// File: rtl/ysyx_25020047_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020047_ctrl_if
// Description : Handshake, decode-class and write-enable bundle between the
//               sequencer (master) and the datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_25020047_ctrl_if;
    import ysyx_25020047_ctrl_pkg::*;

    logic ifu_req;
    logic ifu_ack;
    logic ir_wen;
    logic is_load;
    logic is_store;
    logic is_ebreak;
    logic is_illegal;
    logic has_rd;
    logic lsu_req;
    logic lsu_we;
    logic lsu_ack;
    logic reg_wen;
    logic pc_wen;

    modport master (
        output ifu_req, ir_wen, lsu_req, lsu_we, reg_wen, pc_wen,
        input  ifu_ack, lsu_ack, is_load, is_store, is_ebreak, is_illegal, has_rd
    );

    modport slave (
        input  ifu_req, ir_wen, lsu_req, lsu_we, reg_wen, pc_wen,
        output ifu_ack, lsu_ack, is_load, is_store, is_ebreak, is_illegal, has_rd
    );

endinterface : ysyx_25020047_ctrl_if
`default_nettype wire

// File: rtl/ysyx_25020047_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020047_tmo_cnt
// Description : Wait-cycle counter; o_expire flags the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25020047_tmo_cnt #(
    parameter int TMO_CYC = 256
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expire
);

    localparam int c_CNT_W = $clog2(TMO_CYC);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == c_CNT_W'(TMO_CYC - 1));

endmodule : ysyx_25020047_tmo_cnt
`default_nettype wire

// File: rtl/ysyx_25020047_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020047_ctrl_fsm
// Description : Multi-cycle RV32 sequencer: fetch/mem handshakes, write-enable
//               gating, retire counting and sticky halt with reason code.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25020047_ctrl_fsm
    import ysyx_25020047_ctrl_pkg::*;
#(
    parameter int TMO_CYC = 256,
    parameter int CNT_W   = 64
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_start,
    ysyx_25020047_ctrl_if.master    bus,
    output logic                    o_halt,
    output logic [1:0]              o_halt_code,
    output logic [ST_W-1:0]         o_state,
    output logic [CNT_W-1:0]        o_cycle_cnt,
    output logic [CNT_W-1:0]        o_instret
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_halt_code;
    logic [1:0]         w_halt_code_nxt;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_instret;
    logic               w_waiting;
    logic               w_tmo_clr;
    logic               w_tmo_expire;

    // Timer is held clear outside FETCH/MEM, so every entry starts from zero.
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_tmo_clr = ~w_waiting;

    ysyx_25020047_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmo_clr),
        .i_en     (w_waiting),
        .o_expire (w_tmo_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_halt_code <= 2'd0;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_halt_code <= w_halt_code_nxt;
            if (is_running(r_state)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (r_state == S_WB) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_halt_code_nxt = r_halt_code;
        bus.ifu_req     = 1'b0;
        bus.ir_wen      = 1'b0;
        bus.lsu_req     = 1'b0;
        bus.lsu_we      = 1'b0;
        bus.reg_wen     = 1'b0;
        bus.pc_wen      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.ifu_req = 1'b1;
                // An ack on the expiry cycle still completes the fetch.
                if (bus.ifu_ack) begin
                    bus.ir_wen  = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_tmo_expire) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = HC_IFU_TMO;
                end
            end
            S_DECODE: begin
                if (bus.is_illegal) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = HC_ILLEGAL;
                end else if (bus.is_ebreak) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = HC_EBREAK;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = (bus.is_load || bus.is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.lsu_req = 1'b1;
                bus.lsu_we  = bus.is_store;
                if (bus.lsu_ack) begin
                    w_state_nxt = S_WB;
                end else if (w_tmo_expire) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = HC_LSU_TMO;
                end
            end
            S_WB: begin
                bus.reg_wen = bus.has_rd & ~bus.is_store;
                bus.pc_wen  = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_halt      = (r_state == S_HALT);
    assign o_halt_code = r_halt_code;
    assign o_state     = r_state;
    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instret   = r_instret;

endmodule : ysyx_25020047_ctrl_fsm
`default_nettype wire

// File: tb/tb_ysyx_25020047_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25020047_ctrl_fsm
// Description : Randomized self-checking bench; expected per-cycle traces are
//               generated from instruction class and memory wait counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020047_ctrl_fsm;

    localparam int TMO   = 4;
    localparam int CNT_W = 64;

    localparam int K_ALU    = 0;
    localparam int K_BRANCH = 1;
    localparam int K_LOAD   = 2;
    localparam int K_STORE  = 3;
    localparam int K_EBREAK = 4;
    localparam int K_ILLEGAL = 5;

    // o = {ifu_req, ir_wen, lsu_req, lsu_we, reg_wen, pc_wen}
    typedef struct packed {
        logic [2:0] st;
        logic [5:0] o;
        logic       ia;
        logic       la;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             halt;
    logic [1:0]       halt_code;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret;

    ysyx_25020047_ctrl_if bus ();

    ysyx_25020047_ctrl_fsm #(
        .TMO_CYC (TMO),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .bus         (bus),
        .o_halt      (halt),
        .o_halt_code (halt_code),
        .o_state     (state),
        .o_cycle_cnt (cycle_cnt),
        .o_instret   (instret)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    longint unsigned m_cyc = 0;
    longint unsigned m_ret = 0;
    logic [1:0]      m_hc  = 2'd0;
    exp_t            tr[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic rnd_ack();
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic [5:0] o,
                                input logic ia, input logic la);
        exp_t e;
        e.st = st; e.o = o; e.ia = ia; e.la = la;
        return e;
    endfunction

    // Expected trace: FETCH waits df cycles, MEM waits dm cycles; a wait of
    // TMO or more never acks and ends in a timeout halt.
    task automatic build(input int cls, input int df, input int dm, input bit rd,
                         output bit halted, output logic [1:0] hc);
        bit mem = (cls == K_LOAD) || (cls == K_STORE);
        bit st  = (cls == K_STORE);
        tr.delete();
        halted = 1'b0;
        hc     = 2'd0;
        if (df >= TMO) begin
            for (int k = 0; k < TMO; k++) tr.push_back(mk(3'd1, 6'b100000, 1'b0, rnd_ack()));
            halted = 1'b1; hc = 2'd2;
            return;
        end
        for (int k = 0; k <= df; k++)
            tr.push_back(mk(3'd1, (k == df) ? 6'b110000 : 6'b100000, k == df, rnd_ack()));
        tr.push_back(mk(3'd2, 6'b000000, rnd_ack(), rnd_ack()));
        if (cls == K_ILLEGAL) begin halted = 1'b1; hc = 2'd1; return; end
        if (cls == K_EBREAK)  begin halted = 1'b1; hc = 2'd0; return; end
        tr.push_back(mk(3'd3, 6'b000000, rnd_ack(), rnd_ack()));
        if (mem) begin
            if (dm >= TMO) begin
                for (int k = 0; k < TMO; k++)
                    tr.push_back(mk(3'd4, {2'b00, 1'b1, st, 2'b00}, rnd_ack(), 1'b0));
                halted = 1'b1; hc = 2'd3;
                return;
            end
            for (int k = 0; k <= dm; k++)
                tr.push_back(mk(3'd4, {2'b00, 1'b1, st, 2'b00}, rnd_ack(), k == dm));
        end
        tr.push_back(mk(3'd5, {4'b0000, rd & ~st, 1'b1}, rnd_ack(), rnd_ack()));
    endtask

    task automatic step(input exp_t e, input int idx);
        @(negedge clk);
        bus.ifu_ack = e.ia;
        bus.lsu_ack = e.la;
        #1;
        chk($sformatf("state[%0d]", idx), state, e.st);
        chk($sformatf("outs[%0d]", idx),
            {bus.ifu_req, bus.ir_wen, bus.lsu_req, bus.lsu_we, bus.reg_wen, bus.pc_wen, halt},
            {e.o, 1'b0});
    endtask

    task automatic run_instr(input int cls, input int df, input int dm, input bit rd,
                             input int stop_at);
        bit         halted;
        logic [1:0] hc;
        bus.is_load    = (cls == K_LOAD);
        bus.is_store   = (cls == K_STORE);
        bus.is_ebreak  = (cls == K_EBREAK) || ((cls == K_ILLEGAL) && $urandom_range(0, 1) == 1);
        bus.is_illegal = (cls == K_ILLEGAL);
        bus.has_rd     = rd;
        build(cls, df, dm, rd, halted, hc);
        foreach (tr[i]) begin
            step(tr[i], i);
            if (i == 0) begin
                chk("cycle_cnt@fetch", cycle_cnt, m_cyc);
                chk("instret@fetch", instret, m_ret);
            end
            if (i == stop_at) return;
        end
        m_cyc += tr.size();
        if (!halted) m_ret++;
        else m_hc = hc;
    endtask

    task automatic halt_hold(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.ifu_ack = 1'b0;
            bus.lsu_ack = 1'b0;
            start = 1'($urandom_range(0, 1));
            #1;
            chk("halt_state", {halt, state}, {1'b1, 3'd6});
            chk("halt_code", halt_code, m_hc);
            chk("halt_counters", {cycle_cnt, instret}, {m_cyc, m_ret});
        end
        start = 1'b0;
    endtask

    // Caller positions time mid-cycle; reset takes effect without a clock edge.
    task automatic apply_reset();
        rst = 1'b0;
        bus.ifu_ack = 1'b0;
        bus.lsu_ack = 1'b0;
        #1;
        chk("rst_outs",
            {bus.ifu_req, bus.ir_wen, bus.lsu_req, bus.lsu_we, bus.reg_wen, bus.pc_wen,
             halt, halt_code, state}, 0);
        chk("rst_counters", {cycle_cnt, instret}, 0);
        @(negedge clk);
        rst = 1'b1;
        m_cyc = 0;
        m_ret = 0;
        m_hc  = 2'd0;
        @(negedge clk);
        #1;
        chk("idle_after_rst", state, 3'd0);
        chk("counters_after_rst", {cycle_cnt, instret}, 0);
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0;
        bus.is_load = 1'b0; bus.is_store = 1'b0; bus.is_ebreak = 1'b0;
        bus.is_illegal = 1'b0; bus.has_rd = 1'b0;

        #12;
        apply_reset();
        @(negedge clk); #1;
        chk("idle_no_start", state, 3'd0);

        go();
        run_instr(K_ALU, 0, 0, 1'b1, -1);
        run_instr(K_LOAD, 0, 3, 1'b1, -1);
        run_instr(K_STORE, 1, 0, 1'b0, -1);
        run_instr(K_BRANCH, 2, 0, 1'b0, -1);
        for (int n = 0; n < 40; n++)
            run_instr($urandom_range(K_ALU, K_STORE), $urandom_range(0, TMO - 1),
                      $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)), -1);
        run_instr(K_ALU, TMO - 1, 0, 1'b1, -1);
        run_instr(K_LOAD, 0, TMO - 1, 1'b1, -1);
        run_instr(K_ILLEGAL, 0, 0, 1'b1, -1);
        halt_hold(5);

        @(negedge clk); #2;
        apply_reset();
        go();
        run_instr(K_ALU, 1, 0, 1'b1, -1);
        run_instr(K_EBREAK, 0, 0, 1'b0, -1);
        halt_hold(4);

        @(negedge clk); #2;
        apply_reset();
        go();
        run_instr(K_ALU, TMO, 0, 1'b1, -1);
        halt_hold(3);

        @(negedge clk); #2;
        apply_reset();
        go();
        run_instr(K_STORE, 0, TMO + 2, 1'b0, -1);
        halt_hold(3);

        @(negedge clk); #2;
        apply_reset();
        go();
        run_instr(K_LOAD, 0, 5, 1'b1, 4);
        #1;
        apply_reset();
        go();
        run_instr(K_ALU, 0, 0, 1'b1, -1);
        run_instr(K_ALU, 0, 0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_ysyx_25020047_ctrl_fsm
`default_nettype wire
